// File: rtl/scntr_if.sv
// rtl/scntr_if.sv - Serial sample in / parallel history out bundle for scntr
//   i_in  : 1-bit serial sample, driven by the master (sampler side)
//   o_out : WIDTH-bit parallel history, driven by the slave (scntr)
interface scntr_if #(
    parameter int WIDTH = 512
);
    logic             i_in;
    logic [WIDTH-1:0] o_out;

    modport master (
        output i_in,
        input  o_out
    );

    modport slave (
        input  i_in,
        output o_out
    );
endinterface

// File: rtl/scntr.sv
// rtl/scntr.sv - Serial-in parallel-out shift history register for the ADPLL datapath
//   i_clk     : system clock, every stage shifts on the rising edge
//   i_rst     : asynchronous active-high reset, forces every stage to RST_VAL
//   bus.i_in  : serial sample shifted into bit 0
//   bus.o_out : registered history, bit 0 newest, bit WIDTH-1 oldest
module scntr #(
    parameter int   WIDTH   = 512,
    parameter logic RST_VAL = 1'b0
) (
    input  logic   i_clk,
    input  logic   i_rst,
    scntr_if.slave bus
);

    // The declaration value gives a defined power-up state so the block
    // works even if reset is never pulsed.
    logic [WIDTH-1:0] r_shift = {WIDTH{RST_VAL}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= {WIDTH{RST_VAL}};
        end else begin
            r_shift <= {r_shift[WIDTH-2:0], bus.i_in};
        end
    end

    // Output comes straight from the flops: no combinational path from i_in.
    assign bus.o_out = r_shift;

endmodule

// File: tb/tb_scntr.sv
// tb/tb_scntr.sv - Scoreboard bench for scntr
module tb_scntr;

    localparam int W = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;

    scntr_if #(.WIDTH(W)) intf ();

    scntr #(.WIDTH(W), .RST_VAL(1'b0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (intf)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] model = '0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] ones_v;
    logic [W-1:0] one_v;

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty got %h want queued value", tag, intf.o_out);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, intf.o_out, e);
        end
    endtask

    // Called at posedge+1: drive the sample, predict, wait one edge, compare.
    task automatic step(input logic v, input string tag);
        intf.i_in = v;
        model = {model[W-2:0], v};
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        ones_v = '1;
        one_v  = '0;
        one_v[0] = 1'b1;
        intf.i_in = 1'b0;

        // power-up value without any reset pulse, before the first edge
        #1;
        check_val("powerup", intf.o_out, '0);

        // 1. idle
        @(posedge clk);
        #1;
        check_val("idle_e1", intf.o_out, '0);
        model = '0;
        for (int i = 0; i < 4; i++) step(1'b0, "idle");

        // 2/3. 4-cycle pulse, travel and exit
        for (int i = 0; i < 4; i++) step(1'b1, "pulse_in");
        check_val("pulse_4", intf.o_out, {{(W-4){1'b0}}, 4'b1111});
        for (int i = 0; i < 4; i++) step(1'b0, "pulse_mv");
        check_val("pulse_8", intf.o_out, {{(W-8){1'b0}}, 8'b1111_0000});
        for (int e = 9; e <= 516; e++) begin
            step(1'b0, "pulse_run");
            if (e == 515) check_val("pulse_515", intf.o_out, one_v << (W-1));
            if (e == 516) check_val("pulse_exit", intf.o_out, '0);
        end

        // 4. fill
        for (int e = 1; e <= 520; e++) begin
            step(1'b1, "fill");
            if (e == 511) check_val("fill_511", intf.o_out, ones_v >> 1);
            if (e == 512) check_val("fill_512", intf.o_out, ones_v);
            if (e == 520) check_val("fill_520", intf.o_out, ones_v);
        end
        step(1'b0, "drain1");
        check_val("drain1_c", intf.o_out, ones_v << 1);

        // 5. asynchronous reset pulse between edges
        step(1'b1, "pre_rst");
        #8;
        rst = 1'b1;
        #1;
        check_val("async_clr", intf.o_out, '0);
        #2;
        rst = 1'b0;
        exp_q.delete();
        model = '0;
        step(1'b1, "post_rst");
        check_val("post_rst_c", intf.o_out, one_v);
        step(1'b1, "post_rst2");

        // 6. reset held across edges with i_in=1
        rst = 1'b1;
        intf.i_in = 1'b1;
        model = '0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            @(posedge clk);
            #1;
            pop_check("rst_held");
        end
        rst = 1'b0;
        step(1'b1, "rel1");
        check_val("rel1_c", intf.o_out, one_v);
        step(1'b0, "rel2");
        check_val("rel2_c", intf.o_out, {{(W-2){1'b0}}, 2'b10});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scntr.md
Name: scntr

Overview:
- Serial-in, parallel-out shift counter for the ADPLL datapath.
- Samples the 1-bit input `i_in` on every rising clock edge and shifts it into a `WIDTH`-bit history register.
- The register is exposed in parallel on `o_out`, so downstream logic (phase/pulse-width measurement) can count or locate the run of 1s.
- Bit 0 always holds the newest sample; bit `WIDTH-1` holds the oldest.

Parameters:
- `WIDTH`, default 512: number of D-FF stages, which is also the width of `o_out`. Legal range is WIDTH >= 2.
- `RST_VAL`, default 1'b0: value loaded into every stage on reset.

Ports:
- `i_clk`  input  1  system clock; all stages update on the rising edge.
- `i_rst`  input  1  reset, asynchronous, active-high. Clears every stage to `RST_VAL` immediately, independent of `i_clk`.
- `i_in`  input  1  serial data sample. Synchronous to `i_clk`; must meet setup/hold.
- `o_out`  output  WIDTH  parallel view of the shift register. Bit 0 is the newest sample.

Behaviour:
- Reset:
  - While `i_rst`=1, all `WIDTH` stages are forced to `RST_VAL`, so `o_out` = {WIDTH{RST_VAL}} (all zeros at default).
  - The clear takes effect asynchronously, with no clock edge needed.
  - While reset is held, clock edges have no effect.
- Power-up / initial value:
  - Each stage initialises to `RST_VAL`, so `o_out` is defined (all zeros) even if `i_rst` is never asserted.
  - The block must be usable without a reset pulse.
- Reset release:
  - The first rising edge after `i_rst` falls performs a normal shift.
  - No extra latency or dead cycles are allowed.
- Shift operation, on each rising edge of `i_clk` with `i_rst`=0:
  - `o_out[0]` <= `i_in`.
  - `o_out[k]` <= `o_out[k-1]` for k = 1..WIDTH-1.
  - The old `o_out[WIDTH-1]` is discarded.
- Latency:
  - `i_in` appears on `o_out[0]` one clock after it is sampled.
  - It appears on `o_out[k]` k+1 clocks after sampling.
- Saturation / wrap:
  - Nothing wraps. After `WIDTH` consecutive 1s, `o_out` is all ones and stays all ones while `i_in`=1.
  - After `WIDTH` consecutive 0s, `o_out` is all zeros.
- Pulse behaviour:
  - A high pulse on `i_in` of exactly P clock samples produces a contiguous run of P ones that moves up one bit position per clock.
  - The run exits the top after WIDTH+P clocks.
- Reset mid-operation: asserting `i_rst` at any time, including between edges, clears all stages at once.
- Simultaneous events: if `i_rst` is asserted coincident with a clock edge, reset wins and `o_out` = all `RST_VAL`.
- Timing and sampling:
  - `o_out` is purely registered, with no combinational path from `i_in` to `o_out`.
  - There is no enable, no parallel load, and no gating of the clock.
- Implementation: one flat register of `WIDTH` bits, or a generate loop of `WIDTH` D-FF instances. Both are acceptable, provided the behaviour above holds for any legal `WIDTH`.

Test Plan:
1. Idle after configuration:
   - Stimulus: hold `i_in`=0, `i_rst`=0, clock 50 MHz, for 5 cycles.
   - Required: `o_out` = 512'h0 throughout, including before the first edge.
2. 4-cycle pulse:
   - Stimulus: `i_in`=1 for exactly 4 rising edges, then 0.
   - Required: after the 4th edge, `o_out[3:0]`=4'b1111 and all other bits are 0.
   - Required: after the next 4 edges, `o_out[7:4]`=4'b1111 and bits [3:0]=0.
   - Required: the run keeps moving up one bit per clock.
3. Pulse exit:
   - Stimulus: continue the 4-cycle-pulse scenario.
   - Required: `o_out`=0 again exactly 516 edges after the first 1 was sampled.
4. Fill:
   - Stimulus: `i_in`=1 for 520 edges.
   - Required: `o_out`=all ones after edge 512 and remains all ones.
   - Required: after one edge with `i_in`=0, `o_out[0]`=0 and `o_out[511:1]` are all ones.
5. Asynchronous reset:
   - Stimulus: with `o_out` non-zero, pulse `i_rst` high for 3 ns midway between edges.
   - Required: `o_out` = 0 within the reset pulse, before any clock edge.
   - Required: the next edge with `i_in`=1 gives `o_out` = 512'h1.
6. Reset held:
   - Stimulus: hold `i_rst`=1 across 3 edges with `i_in`=1.
   - Required: `o_out` stays 0.
   - Required: after release, the first edge shifts normally.
